// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_WB,
        S_ERR
    } lsu_state_t;

    function automatic logic is_legal_f3(
        input logic       is_store,
        input logic [2:0] f3
    );
        if (is_store)
            return f3 inside {F3_B, F3_H, F3_W};
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a load word and extends it.
import lsu_pkg::*;

module load_align (
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = 8'(rdata_i >> {off_i, 3'b000});
        lane_h = 16'(rdata_i >> {off_i[1], 4'b0000});
        unique case (funct3_i)
            F3_B:    data_o = {{24{lane_b[7]}}, lane_b};
            F3_BU:   data_o = {24'h0, lane_b};
            F3_H:    data_o = {{16{lane_h[15]}}, lane_h};
            F3_HU:   data_o = {16'h0, lane_h};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit with a valid/ready data-memory port,
// load alignment, timeout abort and a one-cycle register-file writeback.
import lsu_pkg::*;

module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        busy,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        err_valid,
    output logic [31:0] err_addr
);

    localparam logic [CNT_WIDTH-1:0] TMAX =
        CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    lsu_state_t          state_q;
    logic [2:0]          f3_q;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic [4:0]          rd_q;
    logic                st_q;
    logic [3:0]          wstrb_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [31:0]         rdata_q;
    logic                done_q;
    logic                wb_valid_q;
    logic                err_valid_q;

    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;
    logic        bad_d;
    logic        to_hit;
    logic [31:0] align_out;

    load_align u_align (
        .rdata_i  (mem_rdata),
        .off_i    (addr_q[1:0]),
        .funct3_i (f3_q),
        .data_o   (align_out)
    );

    always_comb begin
        wstrb_d = 4'b0000;
        wdata_d = req_wdata << {req_addr[1:0], 3'b000};
        if (req_is_store) begin
            unique case (req_funct3[1:0])
                2'b00:   wstrb_d = 4'b0001 << req_addr[1:0];
                2'b01:   wstrb_d = 4'b0011 << req_addr[1:0];
                default: wstrb_d = 4'b1111;
            endcase
        end
        // funct3[1:0] 01 = halfword, 10 = word, for both signed/unsigned
        bad_d = !is_legal_f3(req_is_store, req_funct3)
             || (req_funct3[1:0] == 2'b01 && req_addr[0])
             || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        to_hit = TO_EN && (cnt_q == TMAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            f3_q        <= 3'b000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rd_q        <= 5'd0;
            st_q        <= 1'b0;
            wstrb_q     <= 4'b0000;
            cnt_q       <= '0;
            rdata_q     <= 32'h0;
            done_q      <= 1'b0;
            wb_valid_q  <= 1'b0;
            err_valid_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            wb_valid_q  <= 1'b0;
            err_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= wdata_d;
                        rd_q    <= req_rd;
                        st_q    <= req_is_store;
                        wstrb_q <= wstrb_d;
                        cnt_q   <= '0;
                        if (bad_d) begin
                            state_q     <= S_ERR;
                            err_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        cnt_q <= '0;
                        if (st_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_RESP;
                        end
                    end else if (to_hit) begin
                        state_q     <= S_ERR;
                        err_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (mem_rvalid) begin
                        rdata_q <= align_out;
                        state_q <= S_WB;
                    end else if (to_hit) begin
                        state_q     <= S_ERR;
                        err_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WB: begin
                    wb_valid_q <= (rd_q != 5'd0);
                    done_q     <= 1'b1;
                    state_q    <= S_IDLE;
                end
                S_ERR: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign mem_valid = (state_q == S_REQ);
    assign mem_we    = st_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wstrb = wstrb_q;
    assign mem_wdata = wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = rd_q;
    assign wb_data   = rdata_q;
    assign done      = done_q;
    assign err_valid = err_valid_q;
    assign err_addr  = addr_q;

endmodule
